frvp_spi_int_gen: RTL and testbench

- Generates the SPI controller interrupt from FIFO watermark levels and a sticky RX-overflow flag, then masks and rate-limits it.
- Output auto_out_0 drives the interrupt-crossing source stage directly, so it is registered and glitch-free.
- Sits between the TX/RX FIFOs plus control registers and the interrupt crossing stage.
- Per-source pending bits (ip_*) are exported for the register file to read.

---
 rtl/frvp_spi_int_gen.sv | 143 ++++++++++++++
 tb/tb_frvp_spi_int_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frvp_spi_int_gen.sv
// rtl/frvp_spi_int_gen.sv - SPI interrupt generator: watermark/overflow sources, masking, hold-off
//
// Purpose:
//   Builds the SPI controller interrupt from the TX/RX FIFO watermark levels and
//   a sticky RX-overflow flag. It masks the result with the per-source enables and
//   rate-limits it with a hold-off gap. auto_out_0 is a flop output, so it is
//   glitch-free toward the interrupt crossing stage.
//
// Ports:
//   clock        in   block clock
//   reset        in   synchronous active-low reset
//   tx_count     in   TX FIFO occupancy (CNT_W, unsigned)
//   rx_count     in   RX FIFO occupancy (CNT_W, unsigned)
//   txmark       in   TX watermark (CNT_W, unsigned)
//   rxmark       in   RX watermark (CNT_W, unsigned)
//   ie_txwm      in   TX watermark source enable
//   ie_rxwm      in   RX watermark source enable
//   ie_rxovf     in   RX overflow source enable
//   rx_ovf_evt   in   pulse: RX push while FIFO full
//   clr_rxovf    in   pulse: write-1-to-clear of ip_rxovf
//   coal_cycles  in   minimum low gap after each deassertion (COAL_W)
//   ip_txwm      out  TX watermark pending (level)
//   ip_rxwm      out  RX watermark pending (level)
//   ip_rxovf     out  RX overflow pending (sticky)
//   auto_out_0   out  masked, coalesced interrupt

module frvp_spi_int_gen #(
  parameter int CNT_W  = 4,
  parameter int COAL_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  tx_count,
  input  logic [CNT_W-1:0]  rx_count,
  input  logic [CNT_W-1:0]  txmark,
  input  logic [CNT_W-1:0]  rxmark,
  input  logic              ie_txwm,
  input  logic              ie_rxwm,
  input  logic              ie_rxovf,
  input  logic              rx_ovf_evt,
  input  logic              clr_rxovf,
  input  logic [COAL_W-1:0] coal_cycles,
  output logic              ip_txwm,
  output logic              ip_rxwm,
  output logic              ip_rxovf,
  output logic              auto_out_0
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COAL_W-1:0]   r_cnt;
  logic [COAL_W-1:0]   w_cnt_nxt;
  logic                r_ip_txwm;
  logic                r_ip_rxwm;
  logic                r_ip_rxovf;
  logic                r_irq;
  logic                w_irq_nxt;
  logic                w_irq_req;

  assign w_irq_req = (r_ip_txwm  & ie_txwm)
                   | (r_ip_rxwm  & ie_rxwm)
                   | (r_ip_rxovf & ie_rxovf);

  // State register, pending bits and the registered interrupt output.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ip_txwm  <= 1'b0;
      r_ip_rxwm  <= 1'b0;
      r_ip_rxovf <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ip_txwm  <= (tx_count < txmark);
      r_ip_rxwm  <= (rx_count > rxmark);
      // A new overflow event beats a simultaneous clear so no event is lost.
      if (rx_ovf_evt) begin
        r_ip_rxovf <= 1'b1;
      end else if (clr_rxovf) begin
        r_ip_rxovf <= 1'b0;
      end
      r_irq      <= w_irq_nxt;
    end
  end

  // Next-state logic. coal_cycles is captured only when leaving ASSERT; the
  // hold-off ignores both irq_req and later coal_cycles changes.
  always_comb begin
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_irq_req ? S_ASSERT : S_IDLE;
      end
      S_ASSERT: begin
        if (w_irq_req) begin
          w_state_nxt = S_ASSERT;
        end else if (coal_cycles == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = coal_cycles;
        end
      end
      S_HOLDOFF: begin
        // Exit on cnt==1 gives exactly coal_cycles HOLDOFF cycles; <= also
        // guards a zero count so the FSM can never stall here.
        if (r_cnt <= COAL_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = r_cnt - COAL_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so auto_out_0 is a flop that is high
  // exactly while the state register holds ASSERT.
  always_comb begin
    w_irq_nxt = 1'b0;
    w_irq_nxt = (w_state_nxt == S_ASSERT);
  end

  assign ip_txwm    = r_ip_txwm;
  assign ip_rxwm    = r_ip_rxwm;
  assign ip_rxovf   = r_ip_rxovf;
  assign auto_out_0 = r_irq;

endmodule

// File: tb/tb_frvp_spi_int_gen.sv
// tb/tb_frvp_spi_int_gen.sv - directed scoreboard bench for frvp_spi_int_gen

module tb_frvp_spi_int_gen;

  localparam int CNT_W  = 4;
  localparam int COAL_W = 8;

  localparam int SEL_TX  = 0;
  localparam int SEL_RX  = 1;
  localparam int SEL_OVF = 2;
  localparam int SEL_IRQ = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic [CNT_W-1:0]  tx_count;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  txmark;
  logic [CNT_W-1:0]  rxmark;
  logic              ie_txwm;
  logic              ie_rxwm;
  logic              ie_rxovf;
  logic              rx_ovf_evt;
  logic              clr_rxovf;
  logic [COAL_W-1:0] coal_cycles;
  logic              ip_txwm;
  logic              ip_rxwm;
  logic              ip_rxovf;
  logic              auto_out_0;

  frvp_spi_int_gen #(.CNT_W(CNT_W), .COAL_W(COAL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .txmark      (txmark),
    .rxmark      (rxmark),
    .ie_txwm     (ie_txwm),
    .ie_rxwm     (ie_rxwm),
    .ie_rxovf    (ie_rxovf),
    .rx_ovf_evt  (rx_ovf_evt),
    .clr_rxovf   (clr_rxovf),
    .coal_cycles (coal_cycles),
    .ip_txwm     (ip_txwm),
    .ip_rxwm     (ip_rxwm),
    .ip_rxovf    (ip_rxovf),
    .auto_out_0  (auto_out_0)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    due;
    int    sel;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  function automatic logic observe(input int sel);
    case (sel)
      SEL_TX:  return ip_txwm;
      SEL_RX:  return ip_rxwm;
      SEL_OVF: return ip_rxovf;
      default: return auto_out_0;
    endcase
  endfunction

  // Expect signal 'sel' to read 'val' after 'lat' more clock edges.
  task automatic expect_at(input int sel, input logic val, input int lat, input string tag);
    exp_t e;
    e.due = cyc + lat;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t keep[$];
    logic obs;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        obs = observe(sb[i].sel);
        total++;
        assert (obs === sb[i].val) passed++;
        else $error("FAIL %s cyc=%0d: observed %0b expected %0b", sb[i].tag, cyc, obs, sb[i].val);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      cyc++;
      #1;
      check_due();
    end
  endtask

  initial begin
    // Reset held with every source active.
    reset = 1'b0; tx_count = 4'd0; txmark = 4'd4; rx_count = 4'd15; rxmark = 4'd0;
    ie_txwm = 1'b1; ie_rxwm = 1'b1; ie_rxovf = 1'b1; rx_ovf_evt = 1'b1; clr_rxovf = 1'b0;
    coal_cycles = 8'd0;
    for (int l = 1; l <= 3; l++) begin
      expect_at(SEL_TX,  1'b0, l, "rst_ip_txwm");
      expect_at(SEL_RX,  1'b0, l, "rst_ip_rxwm");
      expect_at(SEL_OVF, 1'b0, l, "rst_ip_rxovf");
      expect_at(SEL_IRQ, 1'b0, l, "rst_irq");
    end
    tick(3);

    // Release with all sources quiet.
    reset = 1'b1; tx_count = 4'd5; rx_count = 4'd0; rx_ovf_evt = 1'b0;
    expect_at(SEL_IRQ, 1'b0, 1, "rel_irq_q1");
    expect_at(SEL_IRQ, 1'b0, 2, "rel_irq_q2");
    tick(2);

    // TX watermark: 5 -> 3 below txmark 4.
    tx_count = 4'd3;
    expect_at(SEL_TX,  1'b1, 1, "tx_ip_on");
    expect_at(SEL_IRQ, 1'b0, 1, "tx_irq_lat1");
    expect_at(SEL_IRQ, 1'b1, 2, "tx_irq_on");
    tick(3);
    tx_count = 4'd4;
    expect_at(SEL_TX,  1'b0, 1, "tx_ip_off");
    expect_at(SEL_IRQ, 1'b1, 1, "tx_irq_hold");
    expect_at(SEL_IRQ, 1'b0, 2, "tx_irq_off");
    expect_at(SEL_IRQ, 1'b0, 3, "tx_irq_idle");
    tick(3);

    // txmark==0 can never be undercut.
    txmark = 4'd0; tx_count = 4'd0;
    expect_at(SEL_TX,  1'b0, 1, "txm0_ip");
    expect_at(SEL_IRQ, 1'b0, 2, "txm0_irq");
    expect_at(SEL_IRQ, 1'b0, 3, "txm0_irq2");
    tick(3);
    txmark = 4'd4; tx_count = 4'd15;
    tick(2);

    // RX watermark boundary.
    rxmark = 4'd2; rx_count = 4'd2;
    expect_at(SEL_RX, 1'b0, 1, "rx_eq_mark");
    tick(1);
    rx_count = 4'd3;
    expect_at(SEL_RX,  1'b1, 1, "rx_above_mark");
    expect_at(SEL_IRQ, 1'b1, 2, "rx_irq_on");
    tick(2);
    rxmark = 4'd15; rx_count = 4'd15;
    expect_at(SEL_RX,  1'b0, 1, "rx_max_mark");
    expect_at(SEL_IRQ, 1'b0, 2, "rx_irq_off");
    tick(3);

    // Sticky overflow, masked first.
    ie_rxovf = 1'b0; rx_ovf_evt = 1'b1;
    expect_at(SEL_OVF, 1'b1, 1, "ovf_set");
    expect_at(SEL_IRQ, 1'b0, 2, "ovf_masked");
    tick(1);
    rx_ovf_evt = 1'b0;
    expect_at(SEL_OVF, 1'b1, 1, "ovf_held1");
    expect_at(SEL_OVF, 1'b1, 2, "ovf_held2");
    tick(2);
    clr_rxovf = 1'b1;
    expect_at(SEL_OVF, 1'b0, 1, "ovf_clr");
    tick(1);
    clr_rxovf = 1'b1; rx_ovf_evt = 1'b1;
    expect_at(SEL_OVF, 1'b1, 1, "ovf_set_wins");
    tick(1);
    clr_rxovf = 1'b0; rx_ovf_evt = 1'b0;
    expect_at(SEL_OVF, 1'b1, 1, "ovf_held3");
    tick(1);
    ie_rxovf = 1'b1;
    expect_at(SEL_IRQ, 1'b1, 1, "ovf_enable_irq");
    tick(2);
    ie_rxovf = 1'b0;
    expect_at(SEL_IRQ, 1'b0, 1, "ovf_disable_irq");
    tick(2);
    clr_rxovf = 1'b1;
    tick(1);
    clr_rxovf = 1'b0;
    tick(1);

    // Coalescing: 5 HOLDOFF + 1 IDLE low cycles before re-assertion.
    coal_cycles = 8'd5; tx_count = 4'd3;
    expect_at(SEL_IRQ, 1'b1, 2, "coal_a_on");
    tick(3);
    tx_count = 4'd4;
    expect_at(SEL_IRQ, 1'b1, 1, "coal_a_hold");
    for (int l = 2; l <= 7; l++) expect_at(SEL_IRQ, 1'b0, l, "coal_a_gap");
    expect_at(SEL_IRQ, 1'b1, 8, "coal_a_reassert");
    expect_at(SEL_IRQ, 1'b1, 9, "coal_a_stay");
    tick(1);
    tx_count = 4'd3;
    tick(8);

    // Same gap with coal_cycles changed mid-HOLDOFF.
    tx_count = 4'd4;
    expect_at(SEL_IRQ, 1'b1, 1, "coal_b_hold");
    for (int l = 2; l <= 7; l++) expect_at(SEL_IRQ, 1'b0, l, "coal_b_gap");
    expect_at(SEL_IRQ, 1'b1, 8, "coal_b_reassert");
    tick(1);
    tx_count = 4'd3;
    tick(2);
    coal_cycles = 8'd1;
    tick(6);
    coal_cycles = 8'd5;
    tick(1);

    // Reset in HOLDOFF with the source still active.
    tx_count = 4'd4;
    tick(1);
    tx_count = 4'd3;
    tick(1);
    reset = 1'b0;
    expect_at(SEL_TX,  1'b0, 1, "rst_hold_ip");
    expect_at(SEL_IRQ, 1'b0, 1, "rst_hold_irq");
    tick(1);
    reset = 1'b1;
    expect_at(SEL_TX,  1'b1, 1, "post_rst_ip");
    expect_at(SEL_IRQ, 1'b0, 1, "post_rst_irq1");
    expect_at(SEL_IRQ, 1'b1, 2, "post_rst_irq2");
    tick(4);

    foreach (sb[i]) begin
      total++;
      $display("FAIL %s: observed unchecked expected checked", sb[i].tag);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
